// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant-lock arbiter slice.
package arb_pkg;

  // Ownership state of the grant-lock stage.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Default maximum number of cycles a single owner may hold the grant.
  localparam int DEFAULT_MAX_HOLD = 16;

  // Widest request vector the index helper can encode.
  localparam int MAX_REQ = 256;

  // Binary index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_prio_pick.sv
// Combinational fixed-priority picker: lowest set bit of the input wins.
module fixed_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] onehot,
  output logic         any_valid
);

  // Isolate the lowest set bit with the two's-complement trick.
  assign onehot    = in & (~in + {{(N-1){1'b0}}, 1'b1});
  assign any_valid = |in;

endmodule

// File: rtl/arb_grant_lock.sv
// Registered, locked grant stage following a fixed-priority pick.
// The grant is held until the owner drops its request, signals done,
// or exceeds MAX_HOLD cycles; a timed-out owner is masked for one pick.
module arb_grant_lock
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           timeout
);

  // Counter wide enough to reach MAX_HOLD-1; kept at one bit when the timeout is disabled.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  generate
    if (N < 2 || N > MAX_REQ) begin : g_bad_n
      $error("arb_grant_lock: N must be between 2 and MAX_REQ");
    end
  endgenerate

  state_t         state;
  logic [N-1:0]   mask;
  logic [HCW-1:0] hold_cnt;

  logic [N-1:0]   eff;
  logic [N-1:0]   eff_oh;
  logic [N-1:0]   req_oh;
  logic           eff_any;
  logic           req_any;
  logic [N-1:0]   pick;
  logic           owner_req;
  logic           hold_limit;

  assign eff = req & ~mask;

  fixed_prio_pick #(.N(N)) u_pick_eff (
    .in        (eff),
    .onehot    (eff_oh),
    .any_valid (eff_any)
  );

  fixed_prio_pick #(.N(N)) u_pick_req (
    .in        (req),
    .onehot    (req_oh),
    .any_valid (req_any)
  );

  // Prefer unmasked requesters; fall back to the raw request so a lone masked requester still wins.
  assign pick       = eff_any ? eff_oh : req_oh;
  assign owner_req  = |(req & grant);
  assign hold_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  assign grant_valid = |grant;

  // Ownership FSM with hold counter, timeout mask and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      timeout  <= 1'b0;
      mask     <= '0;
      hold_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values;
      // timeout is defaulted low here so it can only ever be a one-cycle pulse.
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            grant    <= pick;
            grant_id <= IDW'(onehot_to_idx(MAX_REQ'(pick)));
            hold_cnt <= '0;
            mask     <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || done) begin
            grant <= '0;
            state <= IDLE;
          end else if (hold_limit) begin
            grant   <= '0;
            mask    <= grant;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_grant_lock.sv
// Self-checking bench for arb_grant_lock: a request-level reference model
// pushes expected outputs each edge; a negedge monitor pops and compares.
module tb_arb_grant_lock;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         timeout;

  always #5 clk = ~clk;

  arb_grant_lock #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [1:0]   id;
    logic         valid;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  int   issued[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   to_count    = 0;
  logic prev_valid  = 1'b0;

  // Reference model state: current owner (-1 = none), cycles it has been visible,
  // requester skipped on the next pick (-1 = none), last granted index.
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_mask  = -1;
  int   m_id    = 0;
  logic m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, expv);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int skip);
    int cand;
    cand = -1;
    for (int i = 0; i < N; i++)
      if (r[i] && i != skip && cand < 0) cand = i;
    for (int i = 0; i < N; i++)
      if (r[i] && cand < 0) cand = i;
    return cand;
  endfunction

  // Reference model: advance ownership at every edge and queue the expected outputs.
  always @(posedge clk or posedge rst) begin
    exp_t         e;
    logic [N-1:0] one;
    one = 1;
    if (rst) begin
      m_owner = -1; m_held = 0; m_mask = -1; m_id = 0; m_to = 1'b0;
      exp_q.delete();
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (req != 0) begin
          m_owner = model_pick(req, m_mask);
          m_id    = m_owner;
          m_held  = 1;
          m_mask  = -1;
        end
      end else if (!req[m_owner] || done) begin
        m_owner = -1;
      end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
        m_mask  = m_owner;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end
    e.grant = (m_owner >= 0) ? (one << m_owner) : '0;
    e.id    = 2'(m_id);
    e.valid = (m_owner >= 0);
    e.to    = m_to;
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs with the queued expectation mid-cycle and log new grants.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",       grant,       e.grant);
      check("grant_id",    grant_id,    e.id);
      check("grant_valid", grant_valid, e.valid);
      check("timeout",     timeout,     e.to);
    end
    if (grant_valid && !prev_valid) issued.push_back(int'(grant_id));
    if (timeout) to_count++;
    prev_valid = grant_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [N-1:0] sweep_req [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010,
                                  4'b0110, 4'b1100, 4'b1111, 4'b0000};
  int           sweep_id  [8] = '{0, 1, 2, 3, 1, 1, 2, 0};

  initial begin
    step(3);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a held grant.
    req = 4'b0010;
    step(3);
    check("pre_reset_grant", grant, 4'b0010);
    #1 rst = 1'b1;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_valid", grant_valid, 0);
    check("async_rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("post_reset_grant", grant, 4'b0010);
    check("post_reset_id", grant_id, 1);
    req = '0;
    step(2);

    // Priority pick, no preemption, release on done with a bubble.
    req = 4'b1100;
    step(1);
    check("prio_grant", grant, 4'b0100);
    check("prio_id", grant_id, 2);
    req = 4'b1101;
    step(2);
    check("no_preempt", grant, 4'b0100);
    done = 1'b1;
    step(1);
    done = 1'b0;
    check("done_release", grant, 0);
    step(1);
    check("after_bubble", grant, 4'b0001);
    req = '0;
    step(2);

    // Owner drops its request.
    req = 4'b1000;
    step(1);
    check("drop_grant", grant, 4'b1000);
    req = '0;
    step(1);
    check("drop_release", grant, 0);
    check("drop_no_timeout", timeout, 0);
    step(1);

    // Hold limit: four visible cycles, timeout pulse, masked requester skipped.
    req = 4'b0011;
    step(1);
    check("to_first", grant, 4'b0001);
    step(3);
    check("to_still_held", grant, 4'b0001);
    step(1);
    check("to_release", grant, 0);
    check("to_pulse", timeout, 1);
    step(1);
    check("to_masked_skip", grant, 4'b0010);
    check("to_pulse_end", timeout, 0);
    req = '0;
    step(2);

    // done and hold limit in the same cycle: done wins, no mask.
    req = 4'b0011;
    step(1);
    check("coll_grant", grant, 4'b0001);
    step(3);
    done = 1'b1;
    step(1);
    done = 1'b0;
    check("coll_release", grant, 0);
    check("coll_no_timeout", timeout, 0);
    step(1);
    check("coll_regrant", grant, 4'b0001);
    req = '0;
    step(2);

    // Only the masked requester is requesting.
    req = 4'b0001;
    step(4);
    check("mo_held", grant, 4'b0001);
    step(1);
    check("mo_timeout", timeout, 1);
    step(1);
    check("mo_regrant", grant, 4'b0001);
    req = '0;
    step(2);

    // Sweep of request patterns with done after each grant.
    issued.delete();
    for (int p = 0; p < 9; p++) begin
      req = sweep_req[p];
      step(1);
      done = 1'b1;
      step(1);
      done = 1'b0;
      req  = '0;
      step(1);
    end
    check("sweep_count", issued.size(), 8);
    for (int i = 0; i < 8 && i < issued.size(); i++)
      check($sformatf("sweep_id_%0d", i), issued[i], sweep_id[i]);

    // Randomised traffic, occasional resets; the scoreboard checks every cycle.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      done = ($urandom_range(5) == 0);
      if ($urandom_range(200) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step(1);
    end
    req  = '0;
    done = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
